// File: rtl/pattern_seq_pkg.sv
//==============================================================================
// pattern_seq_pkg -- shared encodings and defaults for the pattern sequencer (rev 1.0)
//==============================================================================
`default_nettype none

package pattern_seq_pkg;

  localparam int DEF_DEPTH = 8;
  localparam int DEF_OUT_W = 2;
  localparam int DEF_CNT_W = 8;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_CONT    = 2'd1;
  localparam logic [1:0] MODE_REPEAT  = 2'd2;
  localparam logic [1:0] MODE_RSVD    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Entry 0 sits in the least significant bits.
  localparam logic [15:0] DEF_TABLE = {2'd0, 2'd3, 2'd1, 2'd2, 2'd2, 2'd1, 2'd3, 2'd0};

  function automatic int default_code(input int idx);
    return int'(DEF_TABLE[2*(idx % 8) +: 2]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pattern_table.sv
//==============================================================================
// pattern_table -- DEPTH x OUT_W register file, reset to the default pattern (rev 1.0)
//==============================================================================
`default_nettype none

module pattern_table
  import pattern_seq_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int OUT_W = DEF_OUT_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [OUT_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [OUT_W-1:0] rdata
);

  logic [OUT_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= OUT_W'(default_code(i));
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/pattern_seq_ctrl.sv
//==============================================================================
// pattern_seq_ctrl -- plays the pattern table one-shot, continuously or N passes (rev 1.0)
//==============================================================================
`default_nettype none

module pattern_seq_ctrl
  import pattern_seq_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int OUT_W = DEF_OUT_W,
  parameter int CNT_W = DEF_CNT_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [OUT_W-1:0] cfg_data,
  input  logic [AW:0]      cfg_len,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] passes,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    step_idx
);

  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  state_t           state, state_n;
  logic [AW-1:0]    idx, idx_n;
  logic [AW:0]      len_q, len_n;
  logic [1:0]       mode_q, mode_n;
  logic [CNT_W-1:0] pass_q, pass_n;
  logic             done_q, done_n;

  logic             advance;
  logic             last;
  logic             tbl_we;
  logic [OUT_W-1:0] tbl_rdata;

  // Host writes only land while idle and not racing a start request.
  assign tbl_we = cfg_we && (state == ST_IDLE) && !start;

  pattern_table #(
    .DEPTH (DEPTH),
    .OUT_W (OUT_W)
  ) u_table (
    .clock (clock),
    .reset (reset),
    .we    (tbl_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (idx),
    .rdata (tbl_rdata)
  );

  assign last = ({1'b0, idx} == (len_q - (AW+1)'(1)));

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      idx    <= '0;
      len_q  <= '0;
      mode_q <= MODE_ONESHOT;
      pass_q <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      len_q  <= len_n;
      mode_q <= mode_n;
      pass_q <= pass_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    len_n   = len_q;
    mode_n  = mode_q;
    pass_n  = pass_q;
    done_n  = 1'b0;
    advance = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start && !stop && (cfg_len != '0)) begin
          state_n = ST_RUN;
          idx_n   = '0;
          len_n   = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
          mode_n  = mode;
          pass_n  = (passes == '0) ? CNT_W'(1) : passes;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_n = ST_IDLE;
          idx_n   = '0;
          pass_n  = '0;
        end else if (hold) begin
          state_n = ST_HOLD;
        end else begin
          advance = 1'b1;
        end
      end
      ST_HOLD: begin
        if (stop) begin
          state_n = ST_IDLE;
          idx_n   = '0;
          pass_n  = '0;
        end else if (!hold) begin
          advance = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        idx_n   = '0;
      end
    endcase

    // Shared step rule for a normal RUN cycle and a HOLD release.
    if (advance) begin
      state_n = ST_RUN;
      if (!last) begin
        idx_n = idx + AW'(1);
      end else begin
        case (mode_q)
          MODE_CONT: begin
            idx_n = '0;
          end
          MODE_REPEAT: begin
            if (pass_q <= CNT_W'(1)) begin
              state_n = ST_IDLE;
              idx_n   = '0;
              pass_n  = '0;
              done_n  = 1'b1;
            end else begin
              idx_n  = '0;
              pass_n = pass_q - CNT_W'(1);
            end
          end
          default: begin
            state_n = ST_IDLE;
            idx_n   = '0;
            pass_n  = '0;
            done_n  = 1'b1;
          end
        endcase
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign out_valid = (state == ST_RUN);
  assign done      = done_q;
  assign step_idx  = idx;
  assign out       = busy ? tbl_rdata : '0;

endmodule

`default_nettype wire
